store_align_buffer: RTL and testbench

STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

---
 rtl/store_pkg.sv | 20 ++
 rtl/store_lane_align.sv | 48 ++++
 rtl/store_align_buffer.sv | 120 ++++++++++++
 tb/tb_store_align_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared store encodings and the buffered-entry payload for store_align_buffer.
// Entry fields are sized for the widest legal configuration.
package store_pkg;

  localparam logic [1:0] ST_WORD  = 2'b00;
  localparam logic [1:0] ST_BYTE  = 2'b01;
  localparam logic [1:0] ST_HALF  = 2'b10;
  localparam logic [1:0] ST_DWORD = 2'b11;

  localparam int unsigned MAX_ADDR_W = 64;
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
    logic [MAX_STRB_W-1:0] wstrb;
  } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering: maps {offset, store type, raw data} to bus wdata/wstrb.
// Offsets are always forced down to natural alignment; misaligned_c_o flags the original offset.
module store_lane_align
  import store_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        type_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] wdata_c_o,
  output logic [STRB_W-1:0] wstrb_c_o,
  output logic              misaligned_c_o
);

  logic [3:0]        nbytes;
  logic [OFF_W-1:0]  align_mask;
  logic [OFF_W-1:0]  off_al;
  logic [STRB_W-1:0] strb_base;
  logic [DATA_W-1:0] byte_mask;

  always_comb begin
    nbytes = 4'd4;
    case (type_i)
      ST_BYTE:  nbytes = 4'd1;
      ST_HALF:  nbytes = 4'd2;
      ST_DWORD: nbytes = (DATA_W == 64) ? 4'd8 : 4'd4;
      default:  nbytes = 4'd4;
    endcase

    align_mask     = OFF_W'(nbytes - 4'd1);
    misaligned_c_o = (off_i & align_mask) != '0;
    off_al         = off_i & ~align_mask;
    strb_base      = STRB_W'((9'd1 << nbytes) - 9'd1);

    // Widen strobe bits into a byte mask so unused operand bits never reach the bus.
    byte_mask = '0;
    for (int b = 0; b < int'(STRB_W); b++) begin
      byte_mask[b*8 +: 8] = {8{strb_base[b]}};
    end

    wstrb_c_o = strb_base << off_al;
    wdata_c_o = (data_i & byte_mask) << {off_al, 3'b000};
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer: aligns stores onto the memory bus and queues them in a DEPTH-entry FIFO.
// Optional STORE_MISALIGN_CHECK_EN: reject misaligned stores and report them via misalign_err/addr.
module store_align_buffer
  import store_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_type,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] misalign_addr,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned OFF_W = $clog2(STRB_W);

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  store_entry_t      fifo_q [DEPTH];
  store_entry_t      entry_d;
  logic [DATA_W-1:0] al_wdata;
  logic [STRB_W-1:0] al_wstrb;
  logic              al_mis;
  logic              accept, push, pop;

  store_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .off_i          (in_addr[OFF_W-1:0]),
    .type_i         (in_type),
    .data_i         (in_data),
    .wdata_c_o      (al_wdata),
    .wstrb_c_o      (al_wstrb),
    .misaligned_c_o (al_mis)
  );

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign mem_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = mem_valid && mem_ready;
  assign count     = count_q;

  assign mem_addr  = fifo_q[rd_ptr_q].addr[ADDR_W-1:0];
  assign mem_wdata = fifo_q[rd_ptr_q].wdata[DATA_W-1:0];
  assign mem_wstrb = fifo_q[rd_ptr_q].wstrb[STRB_W-1:0];

  always_comb begin
    entry_d       = '0;
    entry_d.addr  = MAX_ADDR_W'({in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
    entry_d.wdata = MAX_DATA_W'(al_wdata);
    entry_d.wstrb = MAX_STRB_W'(al_wstrb);
  end

`ifdef STORE_MISALIGN_CHECK_EN
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;

  assign push          = accept && !al_mis;
  assign misalign_err  = err_q;
  assign misalign_addr = err_addr_q;

  // Misaligned requests are consumed but only reported, never queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= accept && al_mis && !flush;
      if (accept && al_mis && !flush) begin
        err_addr_q <= in_addr;
      end
    end
  end
`else
  logic unused_mis;

  assign unused_mis    = al_mis;
  assign push          = accept;
  assign misalign_err  = 1'b0;
  assign misalign_addr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      fifo_q[wr_ptr_q] <= entry_d;
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed + randomized bench for store_align_buffer (DATA_W=32, DEPTH=4) using a queue-based
// reference model; honours STORE_MISALIGN_CHECK_EN when defined.
module tb_store_align_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } exp_t;

`ifdef STORE_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_data;
  logic [1:0]  in_type;
  logic        flush;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        misalign_err;
  logic [31:0] misalign_addr;
  logic [2:0]  count;

  exp_t        q[$];
  bit          err_m;
  logic [31:0] maddr_m;
  int          ncmp, nfail;

  store_align_buffer #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .in_type       (in_type),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bus image of one store, computed from byte sizes and offsets.
  function automatic void model_entry(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] t, output exp_t e, output bit mis);
    int sz, off, offa;
    longint unsigned m;
    sz   = (t == 2'b01) ? 1 : (t == 2'b10) ? 2 : 4;
    off  = int'(a % 4);
    mis  = (off % sz) != 0;
    offa = off - (off % sz);
    e.addr  = a - 32'(off);
    e.strb  = 4'(((1 << sz) - 1) << offa);
    m       = (64'd1 << (8 * sz)) - 64'd1;
    e.wdata = 32'((64'(d) & m) << (8 * offa));
  endfunction

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_type  = t;
  endtask

  // One clock: check outputs against the model, then advance the model with this cycle's inputs.
  task automatic tick();
    bit   acc, pp, mis;
    exp_t e;
    #1;
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() != 4));
    chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
    chk("misalign_err", 64'(misalign_err), 64'(err_m));
    chk("misalign_addr", 64'(misalign_addr), 64'(maddr_m));
    if (q.size() != 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
      chk("mem_wstrb", 64'(mem_wstrb), 64'(q[0].strb));
    end
    acc = in_valid && (q.size() != 4);
    pp  = mem_ready && (q.size() != 0);
    model_entry(in_addr, in_data, in_type, e, mis);
    @(posedge clk);
    err_m = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        if (CHK_EN && mis) begin
          err_m   = 1'b1;
          maddr_m = in_addr;
        end else begin
          q.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    ncmp = 0; nfail = 0; err_m = 1'b0; maddr_m = '0;
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_misalign_err", 64'(misalign_err), 64'd0);
    chk("rst_misalign_addr", 64'(misalign_addr), 64'd0);
    #2 rst_n = 1'b1;

    // Byte and half lane placement
    drive(1'b1, 32'h1003, 32'h0000_00AB, 2'b01); tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00); tick();
    chk("byte_addr", 64'(mem_addr), 64'h1000);
    chk("byte_wstrb", 64'(mem_wstrb), 64'b1000);
    chk("byte_wdata", 64'(mem_wdata), 64'hAB00_0000);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    drive(1'b1, 32'h1002, 32'h0000_1234, 2'b10); tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("half_wstrb", 64'(mem_wstrb), 64'b1100);
    chk("half_wdata", 64'(mem_wdata), 64'h1234_0000);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;

    // Fill under backpressure, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 32'(i), 2'b00); tick();
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h3010, 32'd4, 2'b00); tick(); tick();
    chk("full_count", 64'(count), 64'd4);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(mem_wdata), 64'(i));
      tick();
    end
    mem_ready = 1'b0;

    // Simultaneous push/pop at count=2, then wrap the pointers
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h4000 + 32'(4 * i), 32'h100 + 32'(i), 2'b00); tick();
    end
    mem_ready = 1'b1;
    drive(1'b1, 32'h4008, 32'h102, 2'b00); tick();
    chk("pushpop_count", 64'(count), 64'd2);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h5000 + 32'(4 * i), 32'h200 + 32'(i), 2'b00); tick();
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    repeat (4) tick();
    mem_ready = 1'b0;

    // Misaligned word store
    drive(1'b1, 32'h2002, 32'hDEAD_BEEF, 2'b00); tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
`ifdef STORE_MISALIGN_CHECK_EN
    chk("mis_err", 64'(misalign_err), 64'd1);
    chk("mis_addr", 64'(misalign_addr), 64'h2002);
    chk("mis_count", 64'(count), 64'd0);
    tick();
    chk("mis_pulse", 64'(misalign_err), 64'd0);
`else
    chk("mis_forced_addr", 64'(mem_addr), 64'h2000);
    chk("mis_forced_wstrb", 64'(mem_wstrb), 64'hF);
    chk("mis_forced_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("mis_err_tied", 64'(misalign_err), 64'd0);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
`endif

    // Flush at count=3 with a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h6000 + 32'(4 * i), 32'h300 + 32'(i), 2'b00); tick();
    end
    drive(1'b1, 32'h600C, 32'h303, 2'b00);
    flush = 1'b1; tick(); flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_mem_valid", 64'(mem_valid), 64'd0);

    // Reset during a stalled transfer
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h7000 + 32'(4 * i), 32'h400 + 32'(i), 2'b00); tick();
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_stall_count", 64'(count), 64'd0);
    chk("rst_stall_in_ready", 64'(in_ready), 64'd1);
    q.delete(); err_m = 1'b0; maddr_m = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 32'h7001, 32'hFFFF_FF55, 2'b01); tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00); tick();
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
      mem_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    mem_ready = 1'b1;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
